awg_ctrl: RTL and testbench

//  Front-panel controller feeding sig_gen: debounces four active-low keys and runs an edit-mode FSM.

---
 rtl/awg_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_awg_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_ctrl.sv
// rtl/awg_ctrl.sv - front-panel key debounce, auto-repeat and waveform parameter editor
// Produces the {run, mode, wave}, frequency, amplitude and phase words consumed by sig_gen.

module awg_key #(
    parameter int DEBOUNCE_CYC = 50000,
    parameter int HOLD_CYC     = 500000,
    parameter int REPEAT_CYC   = 100000,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic ev_o
);
    localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int HW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0]  H_LAST   = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0]  H_RELOAD = HW'(HOLD_CYC - REPEAT_CYC);

    logic           s1_q, s2_q, db_q, armed_q, held_q, press_q, rep_q;
    logic [DBW-1:0] cnt_q;
    logic [HW-1:0]  hold_q;
    logic           stable, accept_press;

    // cnt_q counts cycles since the synced level last changed, saturating once stable.
    assign stable       = (cnt_q == DB_LAST);
    assign accept_press = stable && !s2_q && db_q && armed_q;
    assign ev_o         = press_q | rep_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            db_q    <= 1'b1;
            armed_q <= 1'b0;
            held_q  <= 1'b0;
            press_q <= 1'b0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            s1_q <= key_i;
            s2_q <= s1_q;
            if (s1_q != s2_q) begin
                cnt_q <= '0;
            end else if (!stable) begin
                cnt_q <= cnt_q + DBW'(1);
            end
            press_q <= accept_press;
            rep_q   <= 1'b0;
            // A key held through reset must be seen released before it can press.
            if (stable) begin
                db_q <= s2_q;
                if (s2_q) begin
                    armed_q <= 1'b1;
                end
            end
            if (stable && s2_q) begin
                held_q <= 1'b0;
            end else if (accept_press) begin
                held_q <= 1'b1;
            end
            if (!held_q || !REPEAT_EN) begin
                hold_q <= '0;
            end else if (hold_q == H_LAST) begin
                hold_q <= H_RELOAD;
                rep_q  <= 1'b1;
            end else begin
                hold_q <= hold_q + HW'(1);
            end
        end
    end
endmodule

module awg_ctrl #(
    parameter int DEBOUNCE_CYC = 50000,
    parameter int HOLD_CYC     = 500000,
    parameter int REPEAT_CYC   = 100000,
    parameter int FREQ_INIT    = 100,
    parameter int FREQ_MAX     = 4000,
    parameter int FREQ_STEP    = 10,
    parameter int PHASE_STEP   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_run,
    output logic [4:0]  state,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic        param_upd
);
    typedef enum logic [1:0] {
        MODE_FREQ  = 2'b00,
        MODE_AMP   = 2'b01,
        MODE_PHASE = 2'b10,
        MODE_WAVE  = 2'b11
    } mode_e;

    logic ev_mode, ev_up, ev_down, ev_run, inc, dec;

    awg_key #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
        u_key_mode (.clk(clk), .rst_n(rst_n), .key_i(key_mode), .ev_o(ev_mode));
    awg_key #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
        u_key_up   (.clk(clk), .rst_n(rst_n), .key_i(key_up), .ev_o(ev_up));
    awg_key #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
        u_key_down (.clk(clk), .rst_n(rst_n), .key_i(key_down), .ev_o(ev_down));
    awg_key #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
        u_key_run  (.clk(clk), .rst_n(rst_n), .key_i(key_run), .ev_o(ev_run));

    logic        run_q, run_d, upd_q, upd_d;
    mode_e       mode_q, mode_d;
    logic [1:0]  wave_q, wave_d;
    logic [11:0] freq_q, freq_d;
    logic [2:0]  amp_q, amp_d;
    logic [7:0]  phase_q, phase_d;
    logic [12:0] freq_up, freq_dn;

    // A mode press or an up+down collision swallows the edit.
    assign inc     = ev_up & ~ev_down & ~ev_mode;
    assign dec     = ev_down & ~ev_up & ~ev_mode;
    assign freq_up = {1'b0, freq_q} + 13'(FREQ_STEP);
    assign freq_dn = {1'b0, freq_q} - 13'(FREQ_STEP);

    always_comb begin
        run_d   = run_q;
        mode_d  = mode_q;
        wave_d  = wave_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        phase_d = phase_q;
        if (ev_run) begin
            run_d = ~run_q;
        end
        if (ev_mode) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end
        case (mode_q)
            MODE_FREQ: begin
                if (inc) begin
                    freq_d = (freq_up > 13'(FREQ_MAX)) ? 12'(FREQ_MAX) : freq_up[11:0];
                end else if (dec) begin
                    freq_d = (freq_dn[12] || freq_dn == 13'd0) ? 12'd1 : freq_dn[11:0];
                end
            end
            MODE_AMP: begin
                if (inc && amp_q != 3'd7) begin
                    amp_d = amp_q + 3'd1;
                end else if (dec && amp_q != 3'd0) begin
                    amp_d = amp_q - 3'd1;
                end
            end
            MODE_PHASE: begin
                if (inc) begin
                    phase_d = phase_q + 8'(PHASE_STEP);
                end else if (dec) begin
                    phase_d = phase_q - 8'(PHASE_STEP);
                end
            end
            default: begin
                if (inc) begin
                    wave_d = wave_q + 2'd1;
                end else if (dec) begin
                    wave_d = wave_q - 2'd1;
                end
            end
        endcase
        upd_d = (run_d != run_q) || (mode_d != mode_q) || (wave_d != wave_q) ||
                (freq_d != freq_q) || (amp_d != amp_q) || (phase_d != phase_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b1;
            mode_q  <= MODE_FREQ;
            wave_q  <= 2'd0;
            freq_q  <= 12'(FREQ_INIT);
            amp_q   <= 3'd4;
            phase_q <= 8'd0;
            upd_q   <= 1'b0;
        end else begin
            run_q   <= run_d;
            mode_q  <= mode_d;
            wave_q  <= wave_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            phase_q <= phase_d;
            upd_q   <= upd_d;
        end
    end

    assign state       = {run_q, mode_q, wave_q};
    assign state_freq  = freq_q;
    assign state_amp   = amp_q;
    assign state_phase = phase_q;
    assign param_upd   = upd_q;
endmodule

// File: tb/tb_awg_ctrl.sv
// tb/tb_awg_ctrl.sv - directed bench for awg_ctrl with a timeline model of key events
module tb_awg_ctrl;
    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  key_n = 4'hF;   // [0]=mode [1]=up [2]=down [3]=run
    logic [4:0]  state;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        param_upd;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_count = 0;
    int snap;

    awg_ctrl #(.DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_mode(key_n[0]), .key_up(key_n[1]), .key_down(key_n[2]), .key_run(key_n[3]),
        .state(state), .state_freq(state_freq), .state_amp(state_amp),
        .state_phase(state_phase), .param_upd(param_upd)
    );

    always #5 clk = ~clk;

    // Model: a key level counts once sampled D times in a row; its effect lands 3 edges
    // after the D-th sample. Held up/down repeat H after the press, then every R.
    int cyc = 0;
    int run_len [4];
    bit run_val [4];
    bit acc [4];
    bit armed [4];
    bit held [4];
    int press_at [4];
    int held_until [4];
    int rep_next [4];
    bit ev [4];
    int m_run, m_mode, m_wave, m_freq, m_amp, m_phase;
    bit m_upd;
    bit model_ok = 1'b0;
    bit up_act, dn_act;
    int o_run, o_mode, o_wave, o_freq, o_amp, o_phase;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                run_len[k] = 0; run_val[k] = 1'b1; acc[k] = 1'b1; armed[k] = 1'b0;
                held[k] = 1'b0; press_at[k] = -1; held_until[k] = 0; rep_next[k] = 0;
            end
            m_run = 1; m_mode = 0; m_wave = 0; m_freq = 100; m_amp = 4; m_phase = 0;
            m_upd = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int k = 0; k < 4; k++) begin
                ev[k] = (press_at[k] == cyc);
                if ((k == 1 || k == 2) && held[k] && rep_next[k] == cyc && cyc <= held_until[k]) begin
                    ev[k] = 1'b1;
                    rep_next[k] = rep_next[k] + R;
                end
                if (held[k] && cyc >= held_until[k]) held[k] = 1'b0;
            end
            o_run = m_run; o_mode = m_mode; o_wave = m_wave;
            o_freq = m_freq; o_amp = m_amp; o_phase = m_phase;
            up_act = ev[1] && !ev[2] && !ev[0];
            dn_act = ev[2] && !ev[1] && !ev[0];
            if (ev[3]) m_run = 1 - m_run;
            case (o_mode)
                0: if (up_act) m_freq = (m_freq + 10 > 4000) ? 4000 : m_freq + 10;
                   else if (dn_act) m_freq = (m_freq - 10 < 1) ? 1 : m_freq - 10;
                1: if (up_act) m_amp = (m_amp == 7) ? 7 : m_amp + 1;
                   else if (dn_act) m_amp = (m_amp == 0) ? 0 : m_amp - 1;
                2: if (up_act) m_phase = (m_phase + 8) % 256;
                   else if (dn_act) m_phase = (m_phase + 248) % 256;
                default: if (up_act) m_wave = (m_wave + 1) % 4;
                         else if (dn_act) m_wave = (m_wave + 3) % 4;
            endcase
            if (ev[0]) m_mode = (m_mode + 1) % 4;
            m_upd = (o_run != m_run) || (o_mode != m_mode) || (o_wave != m_wave) ||
                    (o_freq != m_freq) || (o_amp != m_amp) || (o_phase != m_phase);
            for (int k = 0; k < 4; k++) begin
                if (key_n[k] == run_val[k]) run_len[k]++;
                else begin run_val[k] = key_n[k]; run_len[k] = 1; end
                if (run_len[k] == D) begin
                    if (run_val[k]) begin
                        armed[k] = 1'b1;
                        if (!acc[k]) held_until[k] = cyc + 3;
                    end else if (acc[k] && armed[k]) begin
                        press_at[k] = cyc + 3;
                        held[k] = 1'b1;
                        held_until[k] = 32'h7fff_ffff;
                        rep_next[k] = cyc + 3 + H;
                    end
                    acc[k] = run_val[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && model_ok) begin
            n_cmp++;
            if (state !== 5'(m_run * 16 + m_mode * 4 + m_wave) || state_freq !== 12'(m_freq) ||
                state_amp !== 3'(m_amp) || state_phase !== 8'(m_phase) || param_upd !== m_upd) begin
                n_bad++;
                $display("FAIL model_cmp cyc=%0d state=%b/%b freq=%0d/%0d amp=%0d/%0d phase=%0d/%0d upd=%b/%b",
                         cyc, state, 5'(m_run * 16 + m_mode * 4 + m_wave), state_freq, m_freq,
                         state_amp, m_amp, state_phase, m_phase, param_upd, m_upd);
            end
            if (param_upd) upd_count++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [3:0] mask, input int times);
        for (int i = 0; i < times; i++) begin
            key_n = key_n & ~mask;
            wait_neg(8);
            key_n = key_n | mask;
            wait_neg(12);
        end
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        wait_neg(2);
        chk("rst_state", int'(state), 16);
        chk("rst_freq", int'(state_freq), 100);
        chk("rst_amp", int'(state_amp), 4);
        chk("rst_phase", int'(state_phase), 0);
        chk("rst_upd", int'(param_upd), 0);
        rst_n = 1'b1;
        wait_neg(10);
        chk("post_rst_freq", int'(state_freq), 100);
        chk("post_rst_no_upd", upd_count, 0);

        // Bounce then settle low: one step, 7 cycles after the final low
        snap = upd_count;
        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0; wait_neg(2);
            key_n[1] = 1'b1; wait_neg(2);
        end
        key_n[1] = 1'b0;
        wait_neg(6);
        chk("bounce_before", int'(state_freq), 100);
        wait_neg(1);
        chk("bounce_after", int'(state_freq), 110);
        chk("bounce_upd", int'(param_upd), 1);
        wait_neg(2);
        key_n[1] = 1'b1;
        wait_neg(12);
        chk("bounce_one_pulse", upd_count - snap, 1);

        // Hold: press, then +20, then every 5
        key_n[1] = 1'b0;
        wait_neg(6);  chk("hold_pre", int'(state_freq), 110);
        wait_neg(1);  chk("hold_first", int'(state_freq), 120);
        wait_neg(19); chk("hold_wait", int'(state_freq), 120);
        wait_neg(1);  chk("hold_rep1", int'(state_freq), 130);
        wait_neg(5);  chk("hold_rep2", int'(state_freq), 140);
        wait_neg(5);  chk("hold_rep3", int'(state_freq), 150);
        wait_neg(23);
        key_n[1] = 1'b1;
        wait_neg(15);
        chk("hold_final", int'(state_freq), 210);

        // Saturation and wrap
        tap(4'b0001, 1);
        tap(4'b0010, 3);
        chk("amp_top", int'(state_amp), 7);
        snap = upd_count;
        tap(4'b0010, 1);
        chk("amp_sat", int'(state_amp), 7);
        chk("amp_sat_no_upd", upd_count - snap, 0);
        tap(4'b0001, 1);
        tap(4'b0100, 1);
        chk("phase_wrap", int'(state_phase), 248);
        tap(4'b0001, 2);
        key_n[2] = 1'b0;
        wait_neg(150);
        key_n[2] = 1'b1;
        wait_neg(12);
        chk("freq_floor", int'(state_freq), 1);
        snap = upd_count;
        tap(4'b0100, 1);
        chk("freq_sat", int'(state_freq), 1);
        chk("freq_sat_no_upd", upd_count - snap, 0);

        // Mode and wave, run toggle
        tap(4'b0001, 3);
        chk("mode_wave", int'(state[3:2]), 3);
        tap(4'b0010, 5);
        chk("wave_wrap", int'(state[1:0]), 1);
        tap(4'b1000, 1);
        chk("run_toggle", int'(state), 5'b01101);

        // Simultaneous keys
        snap = upd_count;
        tap(4'b0110, 1);
        chk("updown_state", int'(state), 5'b01101);
        chk("updown_no_upd", upd_count - snap, 0);
        tap(4'b0011, 1);
        chk("mode_up_state", int'(state), 5'b00001);
        chk("mode_up_freq", int'(state_freq), 1);
        tap(4'b1010, 1);
        chk("run_up_state", int'(state), 5'b10001);
        chk("run_up_freq", int'(state_freq), 11);

        // Key held through reset
        key_n[1] = 1'b0;
        wait_neg(10);
        chk("pre_rst_press", int'(state_freq), 21);
        rst_n = 1'b0;
        wait_neg(3);
        chk("mid_rst_freq", int'(state_freq), 100);
        rst_n = 1'b1;
        snap = upd_count;
        wait_neg(40);
        chk("held_rst_freq", int'(state_freq), 100);
        chk("held_rst_no_upd", upd_count - snap, 0);
        key_n[1] = 1'b1;
        wait_neg(12);
        tap(4'b0010, 1);
        chk("fresh_press", int'(state_freq), 110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
